// File: rtl/spi_bus_arbiter_if.sv
// Signal bundle joining the SPI bus arbiter, its init-engine requesters and the single io_spi master.
interface spi_bus_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      rx_data;
    logic                  spi_start;
    logic [WIDTH-1:0]      spi_tx_data;
    logic                  spi_done;
    logic [WIDTH-1:0]      spi_rx_data;
    logic                  spi_cs;
    logic [NREQ-1:0]       dev_cs_n;

    modport master (
        input  req, req_data, spi_done, spi_rx_data, spi_cs,
        output grant, done, rx_data, spi_start, spi_tx_data, dev_cs_n
    );

    modport slave (
        output req, req_data, spi_done, spi_rx_data, spi_cs,
        input  grant, done, rx_data, spi_start, spi_tx_data, dev_cs_n
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one io_spi master between NREQ init engines, one whole
// transaction at a time, with chip-select steering onto the owner's active-low enable.
module spi_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 32,
    parameter int GAP_CYCLES = 8
) (
    input logic               clk,
    input logic               rst,
    spi_bus_arbiter_if.master bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        GRANT = 6'b000010,
        START = 6'b000100,
        BUSY  = 6'b001000,
        DONE  = 6'b010000,
        GAP   = 6'b100000
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   sel_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [NREQ-1:0]    grant_r;
    logic [NREQ-1:0]    done_r;
    logic [WIDTH-1:0]   rx_data_r;
    logic [WIDTH-1:0]   spi_tx_data_r;
    logic               sel_found_s;
    logic [PTR_W-1:0]   sel_idx_s;
    logic               spi_start_s;
    logic [NREQ-1:0]    dev_cs_n_s;

    // Index base+k reduced modulo NREQ (NREQ need not be a power of two)
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
        int sum;
        sum = (int'(base) + k) % NREQ;
        return PTR_W'(sum);
    endfunction

    // Round-robin pick: first pending request at or after the pointer
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!sel_found_s && bus.req[wrap_idx(ptr_r, k)]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = wrap_idx(ptr_r, k);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an illegal one-hot code falls back to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (sel_found_s) state_nxt_s = GRANT;
                else             state_nxt_s = IDLE;
            end
            GRANT: state_nxt_s = START;
            START: state_nxt_s = BUSY;
            BUSY: begin
                if (bus.spi_done) state_nxt_s = DONE;
                else              state_nxt_s = BUSY;
            end
            DONE: state_nxt_s = GAP;
            GAP: begin
                if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) state_nxt_s = IDLE;
                else                                     state_nxt_s = GAP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: grant/word latch in IDLE, read-back and done pulse on io_spi completion
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r       <= '0;
            done_r        <= '0;
            rx_data_r     <= '0;
            spi_tx_data_r <= '0;
            ptr_r         <= '0;
            sel_r         <= '0;
            gap_cnt_r     <= '0;
        end else begin
            done_r <= '0;
            case (state_r)
                IDLE: begin
                    if (sel_found_s) begin
                        grant_r       <= NREQ'(1'b1) << sel_idx_s;
                        sel_r         <= sel_idx_s;
                        spi_tx_data_r <= bus.req_data[sel_idx_s*WIDTH +: WIDTH];
                    end
                end
                BUSY: begin
                    // Grant drops together with the done pulse so every enable is high in DONE
                    if (bus.spi_done) begin
                        rx_data_r <= bus.spi_rx_data;
                        done_r    <= grant_r;
                        grant_r   <= '0;
                    end
                end
                DONE: begin
                    ptr_r     <= wrap_idx(sel_r, 1);
                    gap_cnt_r <= '0;
                end
                GAP: gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                default: ;
            endcase
        end
    end

    // Output decode: start strobe from state, chip-select steered by the registered grant
    always_comb begin
        spi_start_s = state_r[2];
        dev_cs_n_s  = ~grant_r | {NREQ{bus.spi_cs}};
    end

    assign bus.grant       = grant_r;
    assign bus.done        = done_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.spi_tx_data = spi_tx_data_r;
    assign bus.spi_start   = spi_start_s;
    assign bus.dev_cs_n    = dev_cs_n_s;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench: a round-robin queue model predicts grant order and words, an io_spi model supplies read-back.
module tb_spi_bus_arbiter;
    localparam int NREQ       = 4;
    localparam int WIDTH      = 32;
    localparam int GAP_CYCLES = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_bus_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
    spi_bus_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct { int idx; logic [WIDTH-1:0] tx; } exp_t;
    exp_t             exp_q[$];
    int               done_q[$];
    logic [WIDTH-1:0] rx_q[$];
    int               total = 0;
    int               bad = 0;
    int               ptr_m = 0;
    int               remaining[NREQ];
    logic [WIDTH-1:0] data_m[NREQ];
    logic [WIDTH-1:0] model_rx = '0;
    int               owner = 0;
    bit               owner_valid = 1'b0;
    int               idle_run = 0;
    bit               seen_act = 1'b0;
    int               slave_s = 0;
    int               slave_cnt = 0;
    int               slave_lat = 0;
    bit               slave_kill = 1'b0;
    bit               stray_req = 1'b0;
    bit               rx_force_en = 1'b0;
    logic [WIDTH-1:0] rx_force = '0;
    exp_t             e_cur;
    int               di;
    logic [WIDTH-1:0] rxe;
    logic [NREQ-1:0]  exp_cs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic fail_event(input string name);
        total++;
        bad++;
        $display("FAIL %s: got an event expected none", name);
    endtask

    // io_spi model: cs low for a latency after start, then a done pulse with a MISO word
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 || slave_kill) begin
                slave_kill   = 1'b0;
                slave_s      = 0;
                bus.spi_cs   = 1'b1;
                bus.spi_done = 1'b0;
            end else begin
                case (slave_s)
                    0: begin
                        if (stray_req) begin
                            stray_req        = 1'b0;
                            bus.spi_done     = 1'b1;
                            bus.spi_rx_data  = WIDTH'($urandom);
                            slave_s          = 3;
                        end else if (bus.spi_start === 1'b1) begin
                            slave_cnt = (slave_lat > 0) ? slave_lat : int'($urandom_range(12, 2));
                            slave_s   = 1;
                        end
                    end
                    1: begin
                        bus.spi_cs = 1'b0;
                        slave_cnt--;
                        if (slave_cnt == 0) slave_s = 2;
                    end
                    2: begin
                        bus.spi_cs      = 1'b1;
                        bus.spi_done    = 1'b1;
                        bus.spi_rx_data = rx_force_en ? rx_force : WIDTH'($urandom);
                        rx_q.push_back(bus.spi_rx_data);
                        slave_s         = 3;
                    end
                    3: begin
                        bus.spi_done = 1'b0;
                        slave_s      = 0;
                    end
                    default: slave_s = 0;
                endcase
            end
        end
    end

    // Monitor: start, chip-select, spacing, done and read-back checks once per cycle
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst !== 1'b1) begin
                if (bus.spi_start === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        fail_event("unexpected_start");
                    end else begin
                        e_cur = exp_q.pop_front();
                        check("grant", 64'(bus.grant), 64'(1) << e_cur.idx);
                        check("spi_tx_data", 64'(bus.spi_tx_data), 64'(e_cur.tx));
                        owner       = e_cur.idx;
                        owner_valid = 1'b1;
                        done_q.push_back(e_cur.idx);
                    end
                end
                exp_cs = '1;
                if (owner_valid && bus.spi_cs === 1'b0) exp_cs[owner] = 1'b0;
                check("dev_cs_n", 64'(bus.dev_cs_n), 64'(exp_cs));
                if (bus.dev_cs_n !== '1) begin
                    if (seen_act && idle_run > 0) begin
                        total++;
                        if (idle_run < GAP_CYCLES) begin
                            bad++;
                            $display("FAIL gap: got %0d idle cycles required %0d", idle_run, GAP_CYCLES);
                        end
                    end
                    seen_act = 1'b1;
                    idle_run = 0;
                end else begin
                    idle_run++;
                end
                if (bus.done !== '0) begin
                    if (done_q.size() == 0 || rx_q.size() == 0) begin
                        fail_event("unexpected_done");
                    end else begin
                        di  = done_q.pop_front();
                        rxe = rx_q.pop_front();
                        check("done", 64'(bus.done), 64'(1) << di);
                        check("rx_data", 64'(bus.rx_data), 64'(rxe));
                        model_rx    = rxe;
                        owner_valid = 1'b0;
                    end
                end else begin
                    check("rx_hold", 64'(bus.rx_data), 64'(model_rx));
                end
            end
        end
    end

    // Requesters: count their dones and drop req in the done cycle after the last one
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b1) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.done[i] === 1'b1 && remaining[i] > 0) begin
                        remaining[i]--;
                        if (remaining[i] == 0) bus.req[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [NREQ-1:0] mask, input int cnt_lo, input int cnt_hi);
        int rem[NREQ];
        bit any;
        int idx;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            rem[i]       = mask[i] ? int'($urandom_range(cnt_hi, cnt_lo)) : 0;
            remaining[i] = rem[i];
            data_m[i]    = WIDTH'($urandom);
        end
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr_m + k) % NREQ;
                if (rem[idx] > 0) begin
                    e.idx = idx;
                    e.tx  = data_m[idx];
                    exp_q.push_back(e);
                    rem[idx]--;
                    ptr_m = (idx + 1) % NREQ;
                    any   = 1'b1;
                    break;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                bus.req_data[i*WIDTH +: WIDTH] = data_m[i];
                bus.req[i] = 1'b1;
            end
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        done_q.delete();
        rx_q.delete();
        for (int i = 0; i < NREQ; i++) remaining[i] = 0;
        bus.req     = '0;
        ptr_m       = 0;
        model_rx    = '0;
        owner_valid = 1'b0;
        seen_act    = 1'b0;
        idle_run    = 0;
    endtask

    task automatic wait_burst();
        int n;
        bit busy;
        n = 0;
        forever begin
            @(negedge clk);
            busy = 1'b0;
            for (int i = 0; i < NREQ; i++) if (remaining[i] > 0) busy = 1'b1;
            if (!busy) break;
            n++;
            if (n > 3000) begin
                fail_event("burst_timeout");
                for (int i = 0; i < NREQ; i++) remaining[i] = 0;
                bus.req = '0;
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (GAP_CYCLES + 4) @(negedge clk);
    endtask

    task automatic latency_single(input logic [NREQ-1:0] mask);
        issue(mask, 1, 1);
        @(posedge clk); #1;
        check("lat_grant", 64'(bus.grant), 64'(mask));
        check("lat_start_early", 64'(bus.spi_start), 64'd0);
        @(posedge clk); #1;
        check("lat_start", 64'(bus.spi_start), 64'd1);
        @(posedge clk); #1;
        check("start_width", 64'(bus.spi_start), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        slave_kill = 1'b1;
        flush_model();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_grant", 64'(bus.grant), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_rx_data", 64'(bus.rx_data), 64'd0);
        check("rst_spi_start", 64'(bus.spi_start), 64'd0);
        check("rst_spi_tx_data", 64'(bus.spi_tx_data), 64'd0);
        check("rst_dev_cs_n", 64'(bus.dev_cs_n), 64'(4'b1111));
    endtask

    initial begin
        rst             = 1'b1;
        bus.req         = '0;
        bus.req_data    = '0;
        bus.spi_done    = 1'b0;
        bus.spi_rx_data = '0;
        bus.spi_cs      = 1'b1;
        for (int i = 0; i < NREQ; i++) remaining[i] = 0;
        repeat (3) @(negedge clk);
        do_reset();

        // Single requester with a long io_spi transfer
        slave_lat = 40;
        latency_single(4'b0001);
        wait_burst();
        settle();
        slave_lat = 0;

        // Read-back of a fixed MISO word
        rx_force_en = 1'b1;
        rx_force    = 32'h0000180C;
        issue(4'b1000, 1, 1);
        wait_burst();
        settle();
        rx_force_en = 1'b0;

        // Contention: three requesters each holding for two transactions
        issue(4'b1011, 2, 2);
        wait_burst();
        settle();

        // Rotation after serving index 1
        issue(4'b0010, 1, 1);
        wait_burst();
        issue(4'b0011, 1, 1);
        wait_burst();
        issue(4'b0010, 1, 1);
        wait_burst();
        issue(4'b1101, 1, 1);
        wait_burst();
        settle();

        // Stray io_spi done while idle, then in the gap
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        latency_single(4'b0100);
        wait_burst();
        stray_req = 1'b1;
        settle();

        // Reset in the middle of a transfer, then normal service
        slave_lat = 40;
        issue(4'b0100, 1, 1);
        repeat (12) @(negedge clk);
        do_reset();
        slave_lat = 0;
        repeat (60) @(negedge clk);
        issue(4'b0011, 1, 1);
        wait_burst();

        // Randomized bursts
        repeat (30) begin
            issue(NREQ'($urandom_range(15, 1)), 1, 3);
            wait_burst();
            repeat ($urandom_range(12, 0)) @(negedge clk);
        end
        settle();

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);
        check("rx_q_empty", 64'(rx_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
